mask_index_gen: RTL and testbench
=================================

MASK_INDEX_GEN -- requirements
Module: mask_index_gen

Interface
REQ-001 SHALL have parameter LENGTH, default 32, giving the mask width in bits.
REQ-002 SHALL have derived parameter IDXW = $clog2(LENGTH), default 5, giving the index/address width.
REQ-003 SHALL have port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port o_mask  input  LENGTH  AND of activation and weight nonzero masks from the upstream mask stage.
REQ-006 SHALL have port i_mask  input  LENGTH  activation nonzero mask.
REQ-007 SHALL have port w_mask  input  LENGTH  weight nonzero mask.
REQ-008 SHALL have port mask_valid  input  1  upstream masks are valid.
REQ-009 SHALL have port mask_taken  output  1  single-cycle acceptance pulse to upstream (drives the upstream output_taken).
REQ-010 SHALL have port idx_valid  output  1  idx_pos/i_addr/w_addr/idx_last are valid.
REQ-011 SHALL have port idx_ready  input  1  consumer accepts the current index.
REQ-012 SHALL have port idx_pos  output  IDXW  bit position of the current matched nonzero pair.
REQ-013 SHALL have port i_addr  output  IDXW  compressed activation offset = popcount(i_mask bits below idx_pos).
REQ-014 SHALL have port w_addr  output  IDXW  compressed weight offset = popcount(w_mask bits below idx_pos).
REQ-015 SHALL have port idx_last  output  1  the current index is the final set bit.
REQ-016 SHALL have port done  output  1  single-cycle pulse at the end of each mask.
REQ-017 SHALL have port pair_count  output  IDXW+1  number of set bits in the last accepted o_mask.
REQ-018 SHALL have port state  output  2  FSM state: IDLE=00, SCAN=01, DONE=10.

Function
REQ-019 In IDLE with mask_valid=1, SHALL latch o_mask, i_mask and w_mask into internal registers, assert mask_taken for exactly that one cycle, and load pair_count=popcount(o_mask).
REQ-020 After an IDLE acceptance, SHALL move to SCAN if the latched o_mask is nonzero, else to DONE.
REQ-021 SHALL assert mask_taken only in IDLE; mask_valid SHALL be ignored in SCAN and DONE.
REQ-022 In SCAN, SHALL hold idx_valid=1 and drive idx_pos = the lowest set bit of the remaining-mask register.
REQ-023 In SCAN, i_addr and w_addr SHALL be computed combinationally from the latched masks.
REQ-024 Latency: first idx_valid SHALL occur the cycle after mask_taken.
REQ-025 Each handshake (idx_valid & idx_ready) SHALL clear that bit in the remaining-mask register; the next index SHALL appear the following cycle, giving one index per cycle at full throughput.
REQ-026 With idx_ready=0, idx_pos, i_addr, w_addr and idx_last SHALL hold stable.
REQ-027 idx_last SHALL be 1 when exactly one bit remains.
REQ-028 A handshake while idx_last=1 SHALL move the FSM to DONE.
REQ-029 In DONE, SHALL assert done for one cycle with idx_valid=0, then return to IDLE.
REQ-030 pair_count SHALL hold until the next acceptance.
REQ-031 Indices SHALL be emitted in ascending bit order.
REQ-032 An all-ones mask SHALL yield LENGTH indices and pair_count=LENGTH (no overflow, hence width IDXW+1).
REQ-033 Outside SCAN, idx_pos, i_addr and w_addr SHALL be 0.

Reset
REQ-034 While reset=0, regardless of clock, SHALL force state=IDLE, clear all mask registers, and set mask_taken, idx_valid, idx_pos, i_addr, w_addr, idx_last, done and pair_count to 0.
REQ-035 Reset asserted mid-SCAN SHALL abort the scan with no done pulse.
REQ-036 Operation SHALL resume at the first rising clk edge after reset deasserts.

Verification
REQ-037 Nominal case: i_mask=0xD3D3D3D3, w_mask=0xB9B89332, o_mask=0x91909312, mask_valid=1, idx_ready=1 -> mask_taken pulse; pair_count=11; first index (pos=1,i_addr=1,w_addr=0), then (pos=4,i_addr=2,w_addr=1); 11 consecutive valid cycles; idx_last on pos=31; done pulse next cycle.
REQ-038 Empty mask: o_mask=0 -> mask_taken, then DONE with done=1, pair_count=0, idx_valid never asserted.
REQ-039 Full mask: all masks 0xFFFFFFFF -> 32 indices, pos=i_addr=w_addr=k for k=0..31, pair_count=32.
REQ-040 Backpressure: nominal stimulus with idx_ready toggled 1,0,0,1 -> outputs held during stalls; sequence identical to the REQ-037 case, only stretched.
REQ-041 Busy ignore: mask_valid held high throughout SCAN -> no mask_taken until the cycle after done; second mask then accepted.
REQ-042 Reset mid-scan: reset=0 after the 3rd index -> all outputs 0, state=00 immediately (asynchronous), no done pulse.

Source files
------------

// File: rtl/mask_index_gen.sv
// -----------------------------------------------------------------------------
// mask_index_gen
//
// Walks the set bits of a matched nonzero mask (o_mask) in ascending order.
// For each set bit it emits the bit position plus the compressed offsets into
// the activation and weight streams. Those offsets are the number of set bits
// in i_mask / w_mask below that position.
//
// Flow: IDLE accepts a mask set (mask_taken pulse). SCAN then emits one index
// per idx_valid & idx_ready handshake. DONE pulses done for one cycle and the
// FSM returns to IDLE.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   o_mask      AND of activation and weight nonzero masks
//   i_mask      activation nonzero mask
//   w_mask      weight nonzero mask
//   mask_valid  upstream masks valid
//   mask_taken  one-cycle acceptance pulse to upstream
//   idx_valid   idx_pos / i_addr / w_addr / idx_last valid
//   idx_ready   consumer accepts the current index
//   idx_pos     bit position of the current matched pair
//   i_addr      popcount(i_mask below idx_pos)
//   w_addr      popcount(w_mask below idx_pos)
//   idx_last    current index is the final set bit
//   done        one-cycle pulse at the end of each mask
//   pair_count  popcount of the last accepted o_mask
//   state       FSM state: IDLE=00, SCAN=01, DONE=10
// -----------------------------------------------------------------------------
module mask_index_gen #(
    parameter int LENGTH = 32,
    parameter int IDXW   = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LENGTH-1:0] o_mask,
    input  logic [LENGTH-1:0] i_mask,
    input  logic [LENGTH-1:0] w_mask,
    input  logic              mask_valid,
    output logic              mask_taken,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic [IDXW-1:0]   idx_pos,
    output logic [IDXW-1:0]   i_addr,
    output logic [IDXW-1:0]   w_addr,
    output logic              idx_last,
    output logic              done,
    output logic [IDXW:0]     pair_count,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SCAN = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [LENGTH-1:0] rem_reg;         // o_mask bits not yet emitted
    logic [LENGTH-1:0] i_mask_reg;
    logic [LENGTH-1:0] w_mask_reg;
    logic [IDXW:0]     pair_count_reg;

    logic              accept;
    logic              handshake;
    logic              in_scan;
    logic              last_bit;
    logic [LENGTH-1:0] low_onehot;
    logic [LENGTH-1:0] below_mask;
    logic [IDXW:0]     pos_cnt;
    logic [IDXW:0]     i_cnt;
    logic [IDXW:0]     w_cnt;

    function automatic logic [IDXW:0] popcnt(input logic [LENGTH-1:0] v);
        logic [IDXW:0] c;
        c = '0;
        for (int k = 0; k < LENGTH; k++) begin
            c = c + (IDXW+1)'(v[k]);
        end
        return c;
    endfunction

    assign in_scan   = (state_reg == ST_SCAN);
    assign accept    = (state_reg == ST_IDLE) && mask_valid;
    assign handshake = in_scan && idx_ready;

    // Isolate the lowest remaining set bit. Every bit below it forms a mask
    // whose popcount is the position, and whose AND with i/w gives the offsets.
    assign low_onehot = rem_reg & (~rem_reg + LENGTH'(1));
    assign below_mask = low_onehot - LENGTH'(1);
    assign pos_cnt    = popcnt(below_mask);
    assign i_cnt      = popcnt(i_mask_reg & below_mask);
    assign w_cnt      = popcnt(w_mask_reg & below_mask);

    // Exactly one bit remains when clearing the lowest one leaves nothing.
    assign last_bit   = (rem_reg != '0) && ((rem_reg & (rem_reg - LENGTH'(1))) == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mask_valid) begin
                    state_next = (o_mask != '0) ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                if (idx_ready && last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Mask and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_reg        <= '0;
            i_mask_reg     <= '0;
            w_mask_reg     <= '0;
            pair_count_reg <= '0;
        end else if (accept) begin
            rem_reg        <= o_mask;
            i_mask_reg     <= i_mask;
            w_mask_reg     <= w_mask;
            pair_count_reg <= popcnt(o_mask);
        end else if (handshake) begin
            rem_reg        <= rem_reg & (rem_reg - LENGTH'(1));
        end
    end

    // Output logic. mask_taken is qualified with reset so that it stays low
    // while reset is held, even though the FSM then reads as IDLE.
    always_comb begin
        mask_taken = accept && reset;
        idx_valid  = in_scan;
        done       = (state_reg == ST_DONE);
        idx_last   = in_scan && last_bit;
        idx_pos    = '0;
        i_addr     = '0;
        w_addr     = '0;
        if (in_scan) begin
            idx_pos = pos_cnt[IDXW-1:0];
            i_addr  = i_cnt[IDXW-1:0];
            w_addr  = w_cnt[IDXW-1:0];
        end
    end

    assign pair_count = pair_count_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_mask_index_gen.sv
module tb_mask_index_gen;

    localparam int LENGTH = 32;
    localparam int IDXW   = 5;

    logic              clk;
    logic              reset;
    logic [LENGTH-1:0] o_mask;
    logic [LENGTH-1:0] i_mask;
    logic [LENGTH-1:0] w_mask;
    logic              mask_valid;
    logic              mask_taken;
    logic              idx_valid;
    logic              idx_ready;
    logic [IDXW-1:0]   idx_pos;
    logic [IDXW-1:0]   i_addr;
    logic [IDXW-1:0]   w_addr;
    logic              idx_last;
    logic              done;
    logic [IDXW:0]     pair_count;
    logic [1:0]        state;

    int n_tests = 0;
    int n_fail  = 0;

    mask_index_gen #(.LENGTH(LENGTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .o_mask     (o_mask),
        .i_mask     (i_mask),
        .w_mask     (w_mask),
        .mask_valid (mask_valid),
        .mask_taken (mask_taken),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx_pos    (idx_pos),
        .i_addr     (i_addr),
        .w_addr     (w_addr),
        .idx_last   (idx_last),
        .done       (done),
        .pair_count (pair_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: number of set bits of v strictly below position p.
    function automatic int below_cnt(input logic [31:0] v, input int p);
        logic [63:0] m;
        m = (64'd1 << p) - 64'd1;
        return $countones({32'd0, v} & m);
    endfunction

    // mode 0: ready always 1; 1: pattern 1,0,0,1; 2: random ready.
    // hold_valid keeps mask_valid high through the whole scan.
    task automatic run_mask(input string name, input logic [31:0] o, input logic [31:0] i,
                            input logic [31:0] w, input int mode, input bit hold_valid);
        int exp_q[$];
        int cyc;
        int stalls;
        int emitted;
        bit rdy;
        for (int p = 0; p < LENGTH; p++) begin
            if (o[p]) exp_q.push_back(p);
        end
        // Acceptance cycle
        @(negedge clk);
        o_mask = o; i_mask = i; w_mask = w; mask_valid = 1'b1; idx_ready = 1'b0;
        #1;
        chk({name, ".taken"}, 64'(mask_taken), 64'd1);
        chk({name, ".idle_state"}, 64'(state), 64'd0);
        chk({name, ".idle_valid"}, 64'(idx_valid), 64'd0);
        @(negedge clk);
        if (!hold_valid) mask_valid = 1'b0;
        o_mask = $urandom; i_mask = $urandom; w_mask = $urandom;   // latched copy must be used
        chk({name, ".pair_count"}, 64'(pair_count), 64'(exp_q.size()));
        cyc = 0;
        stalls = 0;
        emitted = 0;
        while (exp_q.size() > 0) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = (stalls >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            idx_ready = rdy;
            #1;
            chk({name, ".valid"}, 64'(idx_valid), 64'd1);
            chk({name, ".state_scan"}, 64'(state), 64'd1);
            chk({name, ".pos"}, 64'(idx_pos), 64'(exp_q[0]));
            chk({name, ".i_addr"}, 64'(i_addr), 64'(below_cnt(i, exp_q[0])));
            chk({name, ".w_addr"}, 64'(w_addr), 64'(below_cnt(w, exp_q[0])));
            chk({name, ".last"}, 64'(idx_last), 64'(exp_q.size() == 1));
            chk({name, ".busy_taken"}, 64'(mask_taken), 64'd0);
            chk({name, ".no_done"}, 64'(done), 64'd0);
            if (rdy) begin
                void'(exp_q.pop_front());
                emitted++;
                stalls = 0;
            end else begin
                stalls++;
            end
            cyc++;
            @(negedge clk);
        end
        idx_ready = 1'b0;
        #1;
        chk({name, ".done"}, 64'(done), 64'd1);
        chk({name, ".done_state"}, 64'(state), 64'd2);
        chk({name, ".done_valid"}, 64'(idx_valid), 64'd0);
        chk({name, ".done_pos"}, 64'({idx_pos, i_addr, w_addr}), 64'd0);
        chk({name, ".done_taken"}, 64'(mask_taken), 64'd0);
        $display("[TB] %s o=%08h i=%08h w=%08h mode=%0d indices=%0d cycles=%0d",
                 name, o, i, w, mode, emitted, cyc);
    endtask

    initial begin
        reset = 1'b0;
        o_mask = '1; i_mask = '1; w_mask = '1;
        mask_valid = 1'b1;
        idx_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.state", 64'(state), 64'd0);
        chk("rst.taken", 64'(mask_taken), 64'd0);
        chk("rst.outs", 64'({idx_valid, idx_pos, i_addr, w_addr, idx_last, done}), 64'd0);
        chk("rst.pair_count", 64'(pair_count), 64'd0);
        $display("[TB] reset state checked");
        mask_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_mask("nominal", 32'h91909312, 32'hD3D3D3D3, 32'hB9B89332, 0, 1'b0);
        chk("nominal.pair_count_hold", 64'(pair_count), 64'd11);
        run_mask("empty", 32'h0, 32'hD3D3D3D3, 32'hB9B89332, 0, 1'b0);
        run_mask("full", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        chk("full.pair_count_hold", 64'(pair_count), 64'd32);
        run_mask("backpressure", 32'h91909312, 32'hD3D3D3D3, 32'hB9B89332, 1, 1'b0);
        run_mask("busy1", 32'h00F0000F, 32'h0FF0F00F, 32'hF0F0000F, 2, 1'b1);
        run_mask("busy2", 32'h80000001, 32'hC0000003, 32'h80000001, 0, 1'b0);

        // Reset during scan: after the 3rd handshake, drop reset mid-cycle
        @(negedge clk);
        o_mask = 32'h91909312; i_mask = 32'hD3D3D3D3; w_mask = 32'hB9B89332;
        mask_valid = 1'b1; idx_ready = 1'b1;
        @(negedge clk);
        mask_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rstmid.pre_pos", 64'(idx_pos), 64'd9);
        #1;
        reset = 1'b0;
        #1;
        chk("rstmid.state", 64'(state), 64'd0);
        chk("rstmid.outs", 64'({mask_taken, idx_valid, idx_pos, i_addr, w_addr, idx_last, done}), 64'd0);
        chk("rstmid.pair_count", 64'(pair_count), 64'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rstmid.no_done", 64'(done), 64'd0);
        end
        $display("[TB] reset mid-scan checked");
        reset = 1'b1;
        run_mask("resume", 32'h00010100, 32'h00FF0F00, 32'h0001FF00, 0, 1'b0);

        // Randomized masks against the reference model
        for (int t = 0; t < 20; t++) begin
            logic [31:0] ri;
            logic [31:0] rw;
            logic [31:0] ro;
            ri = $urandom;
            rw = $urandom;
            ro = ri & rw;
            if (t % 3 == 1) ro = ro & $urandom;
            run_mask($sformatf("rand%0d", t), ro, ri, rw, t % 3, 1'(t % 4 == 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
